// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl
// Byte-level I2C slave. It decodes START/STOP, matches a 7-bit address,
// acknowledges written bytes and serialises bytes supplied by the host
// on read transfers. SDA is open-drain: the block only ever asks for SDA
// to be pulled low.
//
// Ports
//   sys_clk   system clock, all state changes on its rising edge
//   sys_rst   asynchronous active-high reset
//   scl_in    I2C SCL, already synchronised to sys_clk
//   sda_in    I2C SDA, already synchronised to sys_clk
//   sda_oe    1 = pull SDA low, 0 = release
//   tx_data   byte to send during a read transfer
//   tx_req    one-cycle pulse when tx_data has been latched
//   rx_data   last received data byte
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      1 while in ADDR_ACK, RX, RX_ACK, TX, TX_ACK or WAIT_STOP
//   rw        R/W bit of the current transfer (1 = read)
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  state_t     state;
  logic       scl_q;
  logic       sda_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  // Bit 7 of the byte goes straight to sda_oe when latched, so only the
  // remaining seven bits need holding.
  logic [6:0] tx_shift;
  // Set once the 8th bit of a byte is in (ADDR/RX), or once the master's
  // ACK has been sampled (TX_ACK); consumed on the following SCL fall.
  logic       byte_done;

  logic       scl_rise;
  logic       scl_fall;
  logic       sda_rise;
  logic       sda_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] shift_next;

  // Edges are taken against the live input so they act in the cycle the
  // line changes.
  assign scl_rise   = ~scl_q & scl_in;
  assign scl_fall   = scl_q & ~scl_in;
  assign sda_rise   = ~sda_q & sda_in;
  assign sda_fall   = sda_q & ~sda_in;
  assign start_cond = sda_fall & scl_q & scl_in;
  assign stop_cond  = sda_rise & scl_q & scl_in;
  assign shift_next = {shift_reg[6:0], sda_in};

  assign busy = (state != IDLE) && (state != ADDR);

  // Protocol FSM. START and STOP override everything else; otherwise the
  // state reacts to SCL edges. sda_oe only moves on SCL falls so SDA is
  // stable whenever SCL is high.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      tx_shift  <= 7'h00;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      tx_req    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rw        <= 1'b0;
    end else begin
      scl_q    <= scl_in;
      sda_q    <= sda_in;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;

      if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw        <= sda_in;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (shift_reg[7:1] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!rw) begin
                state  <= RX;
                sda_oe <= 1'b0;
              end else begin
                state    <= TX;
                tx_shift <= tx_data[6:0];
                tx_req   <= 1'b1;
                sda_oe   <= ~tx_data[7];
              end
            end
          end

          RX: begin
            if (scl_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= shift_next;
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              state     <= RX_ACK;
              sda_oe    <= 1'b1;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= RX;
            end
          end

          // bit_cnt counts SCL falls here: the fall ending bit 7-n puts
          // the next bit on SDA, the fall ending bit 0 releases the line.
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                state     <= TX_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_in) begin
                byte_done <= 1'b1;
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              tx_shift  <= tx_data[6:0];
              tx_req    <= 1'b1;
              sda_oe    <= ~tx_data[7];
              bit_cnt   <= 3'd0;
              state     <= TX;
            end
          end

          WAIT_STOP: begin
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl
// Bench for i2c_slave_ctrl. A bit-banged master drives SCL/SDA on a wired-AND
// bus. Each transaction's expected outcome (ACK or not, bytes seen on
// rx_data, bytes shifted out, number of tx_req pulses, ACK pulses from the
// slave) is worked out from the transaction itself; a monitor process
// consumes rx_valid / tx_req pulses against queues filled by the stimulus.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int Q = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       rw;

  int         checks   = 0;
  int         failures = 0;
  int         oe_rises = 0;
  logic [7:0] exp_rx_q[$];
  int         exp_tx_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .scl_in  (scl_m),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .rw      (rw)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid / tx_req pulse and checks
  // that SDA is only ever pulled low while SCL is low.
  initial begin
    logic prev_oe;
    logic [7:0] e;
    prev_oe = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        if (rx_valid) begin
          checkOutput("rx_valid_expected", 32'(exp_rx_q.size() != 0), 1);
          if (exp_rx_q.size() != 0) begin
            e = exp_rx_q.pop_front();
            checkOutput("rx_data", 32'(rx_data), 32'(e));
          end
        end
        if (tx_req) begin
          checkOutput("tx_req_expected", 32'(exp_tx_q.size() != 0), 1);
          if (exp_tx_q.size() != 0) void'(exp_tx_q.pop_front());
        end
        if (sda_oe && !prev_oe) begin
          oe_rises++;
          checkOutput("oe_rise_scl_low", 32'(scl_m), 0);
        end
        prev_oe = sda_oe;
      end else begin
        prev_oe = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    b = sda_bus;
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  // Works from an idle bus or, as a repeated start, from SCL low.
  task automatic do_start();
    if (!scl_m) begin
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
    end
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  // One complete transfer: START, address, n data bytes, STOP.
  // Bytes come from payload, byte i in payload[8*i +: 8]. On reads the
  // master ACKs every byte but the last.
  task automatic applyStimulus(input logic [6:0] addr, input logic rwb, input int n,
                               input logic [31:0] payload);
    logic       match;
    logic       ackbit;
    logic [7:0] got;
    logic [7:0] b;
    int         oe_base;
    match   = (addr == SLAVE_ADDR);
    oe_base = oe_rises;
    if (match && rwb) begin
      tx_data = payload[7:0];
      for (int i = 0; i < n; i++) exp_tx_q.push_back(i);
    end
    do_start();
    checkOutput("busy_in_addr", 32'(busy), 0);
    send_byte({addr, rwb});
    read_bit(ackbit);
    checkOutput("addr_ack_bit", 32'(ackbit), match ? 0 : 1);
    checkOutput("rw", 32'(rw), 32'(rwb));
    checkOutput("busy_after_addr", 32'(busy), 1);
    if (!match) begin
      for (int i = 0; i < n; i++) send_byte(payload[8*i +: 8]);
      checkOutput("wait_stop_busy", 32'(busy), 1);
      checkOutput("nomatch_oe_rises", 32'(oe_rises - oe_base), 0);
    end else if (!rwb) begin
      for (int i = 0; i < n; i++) begin
        b = payload[8*i +: 8];
        exp_rx_q.push_back(b);
        send_byte(b);
        read_bit(ackbit);
        checkOutput("data_ack_bit", 32'(ackbit), 0);
      end
      checkOutput("write_oe_rises", 32'(oe_rises - oe_base), 32'(n + 1));
    end else begin
      for (int i = 0; i < n; i++) begin
        read_byte(got);
        checkOutput("read_byte", 32'(got), 32'(payload[8*i +: 8]));
        if (i < n - 1) begin
          tx_data = payload[8*(i+1) +: 8];
          send_bit(1'b0);
        end else begin
          send_bit(1'b1);
        end
      end
      checkOutput("nack_wait_stop_busy", 32'(busy), 1);
      checkOutput("nack_sda_released", 32'(sda_oe), 0);
    end
    do_stop();
    checkOutput("busy_after_stop", 32'(busy), 0);
    checkOutput("rx_scoreboard_empty", 32'(exp_rx_q.size()), 0);
    checkOutput("tx_req_scoreboard_empty", 32'(exp_tx_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_sda_oe"}, 32'(sda_oe), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_rx_data"}, 32'(rx_data), 0);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 0);
    checkOutput({tag, "_tx_req"}, 32'(tx_req), 0);
    checkOutput({tag, "_rw"}, 32'(rw), 0);
  endtask

  initial begin
    logic       ackbit;
    logic [6:0] a;
    logic       r;
    int         n;
    sys_rst = 1'b1;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    tx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_reset_values("reset");
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("[TB] write 0x42 <- 0xA5");
    applyStimulus(7'h42, 1'b0, 1, 32'h0000_00A5);
    checkOutput("write_rx_data_held", 32'(rx_data), 32'h0A5);

    $display("[TB] write to wrong address 0x43");
    applyStimulus(7'h43, 1'b0, 1, 32'h0000_005A);

    $display("[TB] read 0x42 -> 0x3C, 0xC3");
    applyStimulus(7'h42, 1'b1, 2, 32'h0000_C33C);

    $display("[TB] repeated start inside a data byte");
    do_start();
    send_byte(8'h84);
    read_bit(ackbit);
    checkOutput("rs_addr_ack_bit", 32'(ackbit), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    applyStimulus(7'h42, 1'b1, 1, 32'h0000_0096);

    $display("[TB] reset during a data ACK");
    do_start();
    send_byte(8'h84);
    read_bit(ackbit);
    exp_rx_q.push_back(8'h5A);
    send_byte(8'h5A);
    checkOutput("oe_before_reset", 32'(sda_oe), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check_reset_values("midreset");
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    applyStimulus(7'h42, 1'b0, 2, 32'h0000_7E01);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = SLAVE_ADDR;
      end else begin
        a = 7'($urandom_range(0, 127));
        while (a == SLAVE_ADDR) a = 7'($urandom_range(0, 127));
      end
      r = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      applyStimulus(a, r, n, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 Parameter: SLAVE_ADDR, default 7'h42, 7-bit address this slave answers to.
REQ-002 sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 sys_rst  input  1  reset; asynchronous, active-high.
REQ-004 scl_in  input  1  I2C SCL, already synchronized to sys_clk.
REQ-005 sda_in  input  1  I2C SDA, already synchronized to sys_clk.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 tx_data  input  8  byte to transmit in a read transfer.
REQ-008 tx_req  output  1  1-cycle pulse when tx_data is latched; the host presents the next byte before the next tx_req.
REQ-009 rx_data  output  8  last received data byte.
REQ-010 rx_valid  output  1  1-cycle pulse when rx_data updates.
REQ-011 busy  output  1  1 while addressed (states ADDR_ACK through WAIT_STOP, excluding IDLE/ADDR).
REQ-012 rw  output  1  R/W bit of the current addressed transfer (1 = read).

Function
REQ-013 Edge detection: one register each for scl_in and sda_in (scl_q, sda_q); rise = ~q & in, fall = q & ~in; edges act in the same cycle the input changes.
REQ-014 START = sda fall while scl_q=1 and scl_in=1; STOP = sda rise while scl_q=1 and scl_in=1.
REQ-015 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-016 START in any state -> ADDR, bit counter = 0, sda_oe = 0 (repeated start supported); START/STOP take priority over SCL edges in the same cycle.
REQ-017 STOP in any state -> IDLE, sda_oe = 0.
REQ-018 Data sampled on SCL rise, MSB first, into an 8-bit shift register; 3-bit counter wraps 7 -> 0 at the 8th bit.
REQ-019 ADDR: after the 8th SCL rise, rw = bit 0. On the next SCL fall: if bits[7:1] == SLAVE_ADDR, go ADDR_ACK with sda_oe = 1; otherwise go WAIT_STOP with sda_oe = 0.
REQ-020 ADDR_ACK, on SCL fall: if rw=0, go RX with sda_oe = 0. If rw=1, go TX: latch tx_data, pulse tx_req, sda_oe = ~tx_data[7].
REQ-021 RX: on the 8th SCL rise, rx_data = shifted byte and rx_valid pulses in the following cycle. On the next SCL fall, go RX_ACK with sda_oe = 1.
REQ-022 RX_ACK, on SCL fall: sda_oe = 0, return to RX with counter = 0.
REQ-023 TX: on each SCL fall, sda_oe = ~next bit. After the 8th bit's SCL fall, sda_oe = 0 and go TX_ACK.
REQ-024 TX_ACK: sample SDA on SCL rise. If SDA = 0 (ACK), on the next SCL fall latch tx_data, pulse tx_req, drive bit 7, and go TX. If SDA = 1 (NACK), go WAIT_STOP with sda_oe = 0.
REQ-025 WAIT_STOP: ignore SCL edges; exit only on START or STOP.
REQ-026 sda_oe never changes while scl_in = 1, except when forced to 0 by START/STOP/reset.
REQ-027 IDLE: only START is acted on; SCL/SDA activity otherwise ignored.

Reset
REQ-028 sys_rst = 1 asynchronously sets: state IDLE, sda_oe 0, rx_data 8'h00, rx_valid 0, tx_req 0, busy 0, rw 0, counter 0, scl_q 1, sda_q 1.
REQ-029 Reset asserted mid-transfer aborts immediately: SDA released; no rx_valid or tx_req pulse is emitted.

Verification
REQ-030 Write to 0x42: START, byte 0x84, byte 0xA5, STOP -> ACK (sda_oe = 1) in both ACK slots; rx_data = 0xA5 with one rx_valid pulse; busy = 0 after STOP.
REQ-031 Wrong address: START, byte 0x86 -> sda_oe stays 0 throughout; no rx_valid; state WAIT_STOP until STOP.
REQ-032 Read from 0x42: START, 0x85; tx_data = 0x3C then 0xC3; master ACKs then NACKs -> SDA bit stream 00111100, 11000011; exactly 2 tx_req pulses; WAIT_STOP after NACK.
REQ-033 Repeated start: write 0x84, then START mid-data byte, then read 0x85 -> re-enters ADDR; rw = 1; no rx_valid for the partial byte.
REQ-034 sys_rst pulsed while sda_oe = 1 during a data ACK -> sda_oe = 0 in the same cycle; all outputs at reset values; next START is handled normally.
